// File: rtl/snake_pkg.sv
// Shared encodings for the snake collision controller: FSM states and
// active-low seven-segment glyphs (bit 0 = segment a ... bit 6 = segment g).
package snake_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_HIT  = 2'd2,
    ST_OVER = 2'd3
  } state_e;

  localparam logic [6:0] SEG7_0     = 7'b1000000;
  localparam logic [6:0] SEG7_1     = 7'b1111001;
  localparam logic [6:0] SEG7_2     = 7'b0100100;
  localparam logic [6:0] SEG7_3     = 7'b0110000;
  localparam logic [6:0] SEG7_4     = 7'b0011001;
  localparam logic [6:0] SEG7_5     = 7'b0010010;
  localparam logic [6:0] SEG7_6     = 7'b0000010;
  localparam logic [6:0] SEG7_7     = 7'b1111000;
  localparam logic [6:0] SEG7_8     = 7'b0000000;
  localparam logic [6:0] SEG7_9     = 7'b0010000;
  localparam logic [6:0] SEG7_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_seg7.sv
// One BCD digit to active-low seven-segment pattern. Codes above 9 blank
// the digit rather than showing a misleading glyph.
module bcd_seg7
  import snake_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_n
);

  // Pure lookup from digit value to segment pattern.
  always_comb begin
    case (bcd)
      4'd0:    seg_n = SEG7_0;
      4'd1:    seg_n = SEG7_1;
      4'd2:    seg_n = SEG7_2;
      4'd3:    seg_n = SEG7_3;
      4'd4:    seg_n = SEG7_4;
      4'd5:    seg_n = SEG7_5;
      4'd6:    seg_n = SEG7_6;
      4'd7:    seg_n = SEG7_7;
      4'd8:    seg_n = SEG7_8;
      4'd9:    seg_n = SEG7_9;
      default: seg_n = SEG7_BLANK;
    endcase
  end

endmodule

// File: rtl/snake_collision_ctrl.sv
// Collision, life and score controller for the snake game. Overlaps seen
// while the frame is scanned are latched into sticky flags and acted on at
// the frame tick; all outputs change only on a tick, on start=0 or on rst.
module snake_collision_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned NUM_PREY     = 2,
  parameter int unsigned SIZE_W       = 5,
  parameter int unsigned INIT_SIZE    = 1,
  parameter int unsigned MAX_SIZE     = 31,
  parameter int unsigned LIVES        = 3,
  parameter int unsigned GRACE_FRAMES = 30,
  parameter int unsigned SCORE_DIGITS = 2
) (
  input  logic                      clk_d,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      updateclock,
  input  logic                      border,
  input  logic                      snakeHead,
  input  logic                      snakeBody,
  input  logic [NUM_PREY-1:0]       prey,
  output logic [NUM_PREY-1:0]       eat,
  output logic [SIZE_W-1:0]         size,
  output logic [2:0]                lives_left,
  output logic                      GameOver,
  output logic [7*SCORE_DIGITS-1:0] seg
);

  localparam int unsigned GRACE_W = $clog2(GRACE_FRAMES + 1);
  localparam int unsigned SUM_W   = SIZE_W + 4;
  localparam int unsigned SCORE_W = 4 * SCORE_DIGITS;

  localparam logic [SIZE_W-1:0]  INIT_VAL  = SIZE_W'(INIT_SIZE);
  localparam logic [SUM_W-1:0]   MAX_EXT   = SUM_W'(MAX_SIZE);
  localparam logic [2:0]         LIVES_VAL = 3'(LIVES);
  localparam logic [GRACE_W-1:0] GRACE_VAL = GRACE_W'(GRACE_FRAMES);
  localparam logic [GRACE_W-1:0] GRACE_ONE = GRACE_W'(1);

  state_e               state_q, state_d;
  logic                 lethal_f_q, lethal_f_d;
  logic [NUM_PREY-1:0]  prey_f_q, prey_f_d;
  logic [NUM_PREY-1:0]  eat_q, eat_d;
  logic [SIZE_W-1:0]    size_q, size_d;
  logic [2:0]           lives_q, lives_d;
  logic                 game_over_q, game_over_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [GRACE_W-1:0]   grace_q, grace_d;

  logic                 lethal_now;
  logic [NUM_PREY-1:0]  prey_now;
  logic [3:0]           n_eaten;
  logic [SUM_W-1:0]     size_sum;
  logic [SIZE_W-1:0]    size_sat;
  logic [SCORE_W-1:0]   score_inc;
  logic [4:0]           digit_sum;
  logic [3:0]           digit_carry;

  // Value consumed at a tick: what was latched earlier plus this very cycle.
  always_comb begin
    lethal_now = lethal_f_q | (snakeHead & (border | snakeBody));
    prey_now   = prey_f_q | ({NUM_PREY{snakeHead}} & prey);
  end

  // Prey count, saturating size and saturating BCD score for this tick.
  always_comb begin
    n_eaten = 4'd0;
    for (int i = 0; i < int'(NUM_PREY); i++) begin
      n_eaten = n_eaten + {3'd0, prey_now[i]};
    end

    size_sum = {4'd0, size_q} + {{SIZE_W{1'b0}}, n_eaten};
    size_sat = (size_sum > MAX_EXT) ? MAX_EXT[SIZE_W-1:0] : size_sum[SIZE_W-1:0];

    // Ripple the count into digit 0, then a 0/1 carry through the rest.
    score_inc   = score_q;
    digit_carry = n_eaten;
    digit_sum   = 5'd0;
    for (int i = 0; i < int'(SCORE_DIGITS); i++) begin
      digit_sum = {1'b0, score_q[i*4 +: 4]} + {1'b0, digit_carry};
      if (digit_sum > 5'd9) begin
        score_inc[i*4 +: 4] = 4'(digit_sum - 5'd10);
        digit_carry         = 4'd1;
      end else begin
        score_inc[i*4 +: 4] = digit_sum[3:0];
        digit_carry         = 4'd0;
      end
    end
    // Carry out of the top digit means the display would wrap: pin at all 9s.
    if (digit_carry != 4'd0) begin
      score_inc = {SCORE_DIGITS{4'h9}};
    end
  end

  // Next-state logic: start=0 restarts at any time, everything else waits for the tick.
  always_comb begin
    state_d     = state_q;
    lethal_f_d  = lethal_now;
    prey_f_d    = prey_now;
    eat_d       = '0;
    size_d      = size_q;
    lives_d     = lives_q;
    game_over_d = game_over_q;
    score_d     = score_q;
    grace_d     = grace_q;

    if (!start) begin
      state_d     = ST_IDLE;
      lethal_f_d  = 1'b0;
      prey_f_d    = '0;
      size_d      = INIT_VAL;
      lives_d     = LIVES_VAL;
      game_over_d = 1'b0;
      score_d     = '0;
      grace_d     = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          lethal_f_d = 1'b0;
          prey_f_d   = '0;
          if (updateclock) state_d = ST_PLAY;
        end
        ST_OVER: begin
          lethal_f_d = 1'b0;
          prey_f_d   = '0;
        end
        ST_PLAY, ST_HIT: begin
          if (updateclock) begin
            lethal_f_d = 1'b0;
            prey_f_d   = '0;
            if (state_q == ST_PLAY && lethal_now && lives_q == 3'd1) begin
              // Final life lost: the game ends and any prey this frame is forfeited.
              lives_d     = 3'd0;
              game_over_d = 1'b1;
              state_d     = ST_OVER;
            end else begin
              eat_d   = prey_now;
              size_d  = size_sat;
              score_d = score_inc;
              if (state_q == ST_PLAY && lethal_now) begin
                lives_d = lives_q - 3'd1;
                grace_d = GRACE_VAL;
                state_d = ST_HIT;
              end else if (state_q == ST_HIT) begin
                grace_d = grace_q - GRACE_ONE;
                if (grace_q <= GRACE_ONE) state_d = ST_PLAY;
              end
            end
          end
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_d or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lethal_f_q  <= 1'b0;
      prey_f_q    <= '0;
      eat_q       <= '0;
      size_q      <= INIT_VAL;
      lives_q     <= LIVES_VAL;
      game_over_q <= 1'b0;
      score_q     <= '0;
      grace_q     <= '0;
    end else begin
      state_q     <= state_d;
      lethal_f_q  <= lethal_f_d;
      prey_f_q    <= prey_f_d;
      eat_q       <= eat_d;
      size_q      <= size_d;
      lives_q     <= lives_d;
      game_over_q <= game_over_d;
      score_q     <= score_d;
      grace_q     <= grace_d;
    end
  end

  assign eat        = eat_q;
  assign size       = size_q;
  assign lives_left = lives_q;
  assign GameOver   = game_over_q;

  for (genvar gi = 0; gi < int'(SCORE_DIGITS); gi++) begin : g_digit
    bcd_seg7 u_seg (
      .bcd   (score_q[gi*4 +: 4]),
      .seg_n (seg[gi*7 +: 7])
    );
  end

endmodule
